// File: rtl/axi_wr_burst_feeder.sv
// Write-side burst feeder: FWFT FIFO plus request FSM for the DDR2 AXI write master.
// Optional residual-data flush bursts are compiled in when FLUSH_EN is defined.
module axi_wr_burst_feeder #(
    parameter int                    ADDR_WIDTH = 27,
    parameter int                    DATA_WIDTH = 16,
    parameter int                    FIFO_DEPTH = 64,
    parameter logic [7:0]            BURST_LEN  = 8'd8,
    parameter logic [ADDR_WIDTH-1:0] ADDR_BASE  = 27'd0,
    parameter logic [ADDR_WIDTH-1:0] ADDR_SPAN  = 27'h100000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  init_end,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  in_ready,
    input  logic                  addr_rst,
    input  logic                  flush,
    output logic                  wr_trig,
    output logic [7:0]            wr_len,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  wr_data_en,
    input  logic                  wr_ready,
    input  logic                  wr_done,
    output logic [15:0]           burst_cnt,
    output logic                  err_underrun
);
    localparam int PW    = $clog2(FIFO_DEPTH);
    localparam int LW    = PW + 1;
    localparam int AW    = ADDR_WIDTH;
    localparam int BYTES = DATA_WIDTH / 8;
    localparam logic [AW:0] ADDR_LIM = {1'b0, ADDR_BASE} + {1'b0, ADDR_SPAN};

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_BUSY} state_t;

    state_t                r_state, w_state_nxt;
    logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
    logic [PW-1:0]         r_wr_ptr, r_rd_ptr;
    logic [LW-1:0]         r_level;
    logic                  r_rdy_en;
    logic                  r_err;
    logic [AW-1:0]         r_cur_addr;
    logic                  r_trig;
    logic [7:0]            r_len;
    logic [AW-1:0]         r_addr;
    logic [15:0]           r_cnt;
    logic                  r_apend;

    logic                  w_push, w_pop, w_have_burst;
    logic                  w_trig, w_apend_clr, w_done_adv;
    logic [7:0]            w_len_nxt;
    logic [AW-1:0]         w_trig_addr, w_cur_nxt;
    logic [AW:0]           w_sum;

    assign in_ready     = r_rdy_en && (r_level != LW'(FIFO_DEPTH));
    assign w_push       = in_valid && in_ready;
    assign w_pop        = wr_data_en && (r_level != '0);
    assign wr_data      = r_mem[r_rd_ptr];
    assign w_have_burst = r_level >= LW'(BURST_LEN);
    assign w_trig_addr  = r_apend ? ADDR_BASE : r_cur_addr;

    // Window overflow is detected in AW+1 bits so the carry is not lost.
    assign w_sum     = {1'b0, r_cur_addr} + (AW+1)'(r_len) * (AW+1)'(BYTES);
    assign w_cur_nxt = (w_sum >= ADDR_LIM) ? ADDR_BASE : w_sum[AW-1:0];

    assign wr_trig      = r_trig;
    assign wr_len       = r_len;
    assign wr_addr      = r_addr;
    assign burst_cnt    = r_cnt;
    assign err_underrun = r_err;

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= in_data;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
            r_rdy_en <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_rdy_en <= 1'b1;
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
            if (wr_data_en && r_level == '0) r_err <= 1'b1;
        end
    end

`ifdef FLUSH_EN
    logic r_fpend;
    logic w_fpend_clr;

    always_ff @(posedge clk) begin
        if (!rst_n) r_fpend <= 1'b0;
        else        r_fpend <= flush | (r_fpend & ~w_fpend_clr);
    end
`else
    logic w_unused_flush;
    assign w_unused_flush = flush;
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_trig      = 1'b0;
        w_len_nxt   = BURST_LEN;
        w_apend_clr = 1'b0;
        w_done_adv  = 1'b0;
`ifdef FLUSH_EN
        w_fpend_clr = 1'b0;
`endif
        unique case (r_state)
            S_IDLE: begin
                w_apend_clr = r_apend;
                if (init_end && wr_ready && w_have_burst) begin
                    w_trig      = 1'b1;
                    w_state_nxt = S_REQ;
                end
`ifdef FLUSH_EN
                else if (r_fpend && r_level == '0) begin
                    w_fpend_clr = 1'b1;
                end else if (r_fpend && init_end && wr_ready) begin
                    w_trig      = 1'b1;
                    w_len_nxt   = 8'(r_level);
                    w_fpend_clr = 1'b1;
                    w_state_nxt = S_REQ;
                end
`endif
            end
            S_REQ: w_state_nxt = S_BUSY;
            S_BUSY: begin
                if (wr_done) begin
                    w_done_adv  = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_cur_addr <= ADDR_BASE;
            r_trig     <= 1'b0;
            r_len      <= BURST_LEN;
            r_addr     <= ADDR_BASE;
            r_cnt      <= '0;
            r_apend    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_trig  <= w_trig;
            if (w_trig) begin
                r_addr <= w_trig_addr;
                r_len  <= w_len_nxt;
            end
            r_apend <= addr_rst | (r_apend & ~w_apend_clr);
            // A pending restart wins over the end-of-burst advance.
            if (w_apend_clr)
                r_cur_addr <= ADDR_BASE;
            else if (w_done_adv && !r_apend)
                r_cur_addr <= w_cur_nxt;
            if (w_done_adv) r_cnt <= r_cnt + 16'd1;
        end
    end
endmodule

// File: tb/tb_axi_wr_burst_feeder.sv
// Directed bench for axi_wr_burst_feeder: a default-window instance and a
// 0x20-byte-window instance share all stimulus.
module tb_axi_wr_burst_feeder;
    logic        clk = 1'b0;
    logic        rst_n, init_end, in_valid, addr_rst, flush;
    logic        wr_data_en, wr_ready, wr_done;
    logic [15:0] in_data;

    logic        in_ready, wr_trig, err_underrun;
    logic [7:0]  wr_len;
    logic [26:0] wr_addr;
    logic [15:0] wr_data, burst_cnt;

    logic        w2_in_ready, w2_trig, w2_err;
    logic [7:0]  w2_len;
    logic [26:0] w2_addr;
    logic [15:0] w2_data, w2_cnt;

    int n_chk  = 0;
    int n_fail = 0;
    int n_trig = 0;
    int acc;

    always #5 clk = ~clk;

    axi_wr_burst_feeder u_dut (
        .clk(clk), .rst_n(rst_n), .init_end(init_end),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .addr_rst(addr_rst), .flush(flush),
        .wr_trig(wr_trig), .wr_len(wr_len), .wr_addr(wr_addr),
        .wr_data(wr_data), .wr_data_en(wr_data_en),
        .wr_ready(wr_ready), .wr_done(wr_done),
        .burst_cnt(burst_cnt), .err_underrun(err_underrun)
    );

    axi_wr_burst_feeder #(.ADDR_SPAN(27'h20)) u_wrap (
        .clk(clk), .rst_n(rst_n), .init_end(init_end),
        .in_valid(in_valid), .in_data(in_data), .in_ready(w2_in_ready),
        .addr_rst(addr_rst), .flush(flush),
        .wr_trig(w2_trig), .wr_len(w2_len), .wr_addr(w2_addr),
        .wr_data(w2_data), .wr_data_en(wr_data_en),
        .wr_ready(wr_ready), .wr_done(wr_done),
        .burst_cnt(w2_cnt), .err_underrun(w2_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (wr_trig) n_trig++;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic push_n(input int n, input logic [15:0] d0);
        for (int i = 0; i < n; i++) begin
            in_valid = 1'b1;
            in_data  = d0 + 16'(i);
            tick();
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_trig(input string tag, input logic [26:0] ea,
                             input logic [26:0] ewa, input logic [7:0] el);
        int n = 0;
        while (!wr_trig && n < 60) begin
            tick();
            n++;
        end
        chk({tag, "_trig"}, 32'(wr_trig), 32'd1);
        chk({tag, "_addr"}, 32'(wr_addr), 32'(ea));
        chk({tag, "_wrap_addr"}, 32'(w2_addr), 32'(ewa));
        chk({tag, "_len"}, 32'(wr_len), 32'(el));
        tick();
        chk({tag, "_pulse"}, 32'(wr_trig), 32'd0);
    endtask

    task automatic pop_n(input string tag, input int n, input logic [15:0] d0);
        for (int i = 0; i < n; i++) begin
            chk({tag, "_data"}, 32'(wr_data), 32'(d0 + 16'(i)));
            wr_data_en = 1'b1;
            tick();
        end
        wr_data_en = 1'b0;
    endtask

    task automatic done(input string tag, input logic [15:0] ecnt);
        wr_done = 1'b1;
        tick();
        wr_done = 1'b0;
        chk({tag, "_cnt"}, 32'(burst_cnt), 32'(ecnt));
    endtask

    initial begin
        rst_n = 1'b0; init_end = 1'b0; in_valid = 1'b0; in_data = '0;
        addr_rst = 1'b0; flush = 1'b0; wr_data_en = 1'b0;
        wr_ready = 1'b1; wr_done = 1'b0;
        tick();
        tick();
        chk("rst_trig", 32'(wr_trig), 32'd0);
        chk("rst_len", 32'(wr_len), 32'd8);
        chk("rst_addr", 32'(wr_addr), 32'd0);
        chk("rst_cnt", 32'(burst_cnt), 32'd0);
        chk("rst_err", 32'(err_underrun), 32'd0);
        rst_n = 1'b1;
        tick();
        chk("rst_in_ready", 32'(in_ready), 32'd1);

        // T1: single burst
        init_end = 1'b1;
        push_n(8, 16'h0001);
        wait_trig("t1", 27'h0, 27'h0, 8'd8);
        pop_n("t1", 8, 16'h0001);
        done("t1", 16'd1);

        // T2/T3: held off by init_end, then three bursts; wrap on small window
        do_reset();
        init_end = 1'b0;
        n_trig = 0;
        push_n(24, 16'h0100);
        tick();
        tick();
        chk("t2_no_trig_init", 32'(n_trig), 32'd0);
        init_end = 1'b1;
        wait_trig("t2_b0", 27'h00, 27'h00, 8'd8);
        pop_n("t2_b0", 8, 16'h0100);
        done("t2_b0", 16'd1);
        wait_trig("t2_b1", 27'h10, 27'h10, 8'd8);
        pop_n("t2_b1", 8, 16'h0108);
        done("t2_b1", 16'd2);
        wait_trig("t2_b2", 27'h20, 27'h00, 8'd8);
        pop_n("t2_b2", 8, 16'h0110);
        done("t2_b2", 16'd3);
        chk("t3_wrap_cnt", 32'(w2_cnt), 32'd3);

        // T4: full FIFO, dropped beats, simultaneous push+pop at level 63
        do_reset();
        init_end = 1'b0;
        n_trig = 0;
        acc = 0;
        for (int i = 0; i < 70; i++) begin
            in_valid = 1'b1;
            in_data  = 16'h0200 + 16'(i);
            if (in_ready) acc++;
            tick();
        end
        in_valid = 1'b0;
        chk("t4_accepted", 32'(acc), 32'd64);
        chk("t4_full", 32'(in_ready), 32'd0);
        pop_n("t4_pop1", 1, 16'h0200);
        chk("t4_lvl63_ready", 32'(in_ready), 32'd1);
        chk("t4_pp_head", 32'(wr_data), 32'h0201);
        in_valid = 1'b1; in_data = 16'h0300; wr_data_en = 1'b1;
        tick();
        in_valid = 1'b0; wr_data_en = 1'b0;
        chk("t4_pp_lvl63", 32'(in_ready), 32'd1);
        push_n(1, 16'h0301);
        chk("t4_refull", 32'(in_ready), 32'd0);
        pop_n("t4_drain", 62, 16'h0202);
        pop_n("t4_tail", 2, 16'h0300);
        chk("t4_empty_ready", 32'(in_ready), 32'd1);
        chk("t4_no_err", 32'(err_underrun), 32'd0);
        chk("t4_no_trig", 32'(n_trig), 32'd0);
        wr_data_en = 1'b1;
        tick();
        wr_data_en = 1'b0;
        chk("t4_underrun", 32'(err_underrun), 32'd1);
        tick();
        chk("t4_underrun_sticky", 32'(err_underrun), 32'd1);

        // T5: addr_rst during BUSY, then reset mid-burst
        do_reset();
        init_end = 1'b0;
        push_n(16, 16'h0400);
        init_end = 1'b1;
        wait_trig("t5_b0", 27'h00, 27'h00, 8'd8);
        pop_n("t5_b0", 8, 16'h0400);
        done("t5_b0", 16'd1);
        wait_trig("t5_b1", 27'h10, 27'h10, 8'd8);
        pop_n("t5_b1a", 4, 16'h0408);
        addr_rst = 1'b1;
        tick();
        addr_rst = 1'b0;
        pop_n("t5_b1b", 4, 16'h040C);
        done("t5_b1", 16'd2);
        push_n(8, 16'h0500);
        wait_trig("t5_b2", 27'h00, 27'h00, 8'd8);
        pop_n("t5_b2", 3, 16'h0500);
        rst_n = 1'b0;
        tick();
        chk("t5_rst_trig", 32'(wr_trig), 32'd0);
        chk("t5_rst_len", 32'(wr_len), 32'd8);
        chk("t5_rst_addr", 32'(wr_addr), 32'd0);
        chk("t5_rst_cnt", 32'(burst_cnt), 32'd0);
        chk("t5_rst_err", 32'(err_underrun), 32'd0);
        rst_n = 1'b1;
        tick();
        chk("t5_rst_ready", 32'(in_ready), 32'd1);
        wr_data_en = 1'b1;
        tick();
        wr_data_en = 1'b0;
        chk("t5_level0", 32'(err_underrun), 32'd1);

        // T6: flush of residual data
        do_reset();
        init_end = 1'b1;
        n_trig = 0;
        push_n(3, 16'h0600);
        flush = 1'b1;
        tick();
        flush = 1'b0;
`ifdef FLUSH_EN
        wait_trig("t6_flush", 27'h0, 27'h0, 8'd3);
        pop_n("t6_flush", 3, 16'h0600);
        done("t6_flush", 16'd1);
        push_n(8, 16'h0700);
        wait_trig("t6_next", 27'h6, 27'h6, 8'd8);
        pop_n("t6_next", 8, 16'h0700);
        done("t6_next", 16'd2);
`else
        for (int i = 0; i < 20; i++) tick();
        chk("t6_no_flush_trig", 32'(n_trig), 32'd0);
        chk("t6_cnt", 32'(burst_cnt), 32'd0);
        push_n(5, 16'h0603);
        wait_trig("t6_full", 27'h0, 27'h0, 8'd8);
        pop_n("t6_full", 8, 16'h0600);
        done("t6_full", 16'd1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
